data_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported data memory (`data_mem`) between the pipeline MEM stage (port 0) and a debug/program loader (port 1). Port 0 has fixed priority, and port 1 is protected from starvation by a bounded wait counter. A locked-burst mode lets the loader own memory for consecutive cycles, capped so it cannot stall the pipeline indefinitely. The block sits between the MEM stage, the loader and `data_mem`, and drives the `data_mem` control/address/data inputs.

---
 rtl/data_mem_arbiter_pkg.sv | 25 ++
 rtl/data_mem_arbiter_if.sv | 49 ++++
 rtl/data_mem_arbiter_sat_counter.sv | 29 ++
 rtl/data_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data memory arbiter: state and port encodings,
// default fairness limits and the read-return tag.
package data_mem_arbiter_pkg;

    localparam int CNT_W        = 4;
    localparam int DEF_MAX_WAIT = 4;
    localparam int DEF_MAX_LOCK = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_t;

    // Tag of the read issued last cycle; steers rvalid to the owning port.
    typedef struct packed {
        logic  valid;
        port_t port;
    } rsel_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of the MEM-stage port, the loader port and the data_mem side.
// "master" is the environment (requesters plus memory), "slave" is the arbiter.
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_stall;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_lock;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
        output mem_rdata,
        input  p0_gnt, p0_stall, p0_rvalid, p0_rdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  mem_addr, mem_wdata, mem_read, mem_write
    );

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
        input  mem_rdata,
        output p0_gnt, p0_stall, p0_rvalid, p0_rdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output mem_addr, mem_wdata, mem_read, mem_write
    );

endinterface

// File: rtl/data_mem_arbiter_sat_counter.sv
// Small up-counter that saturates at a run-time limit; clear has priority
// over increment. Used for the loader wait count and the lock burst length.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    input  logic [W-1:0] i_limit,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // Count up to the limit and hold there until cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != i_limit)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbiter sharing the single-ported data_mem between the MEM stage (port 0,
// fixed priority) and the loader (port 1, starvation-bounded, lockable).
//
//   state  | meaning
//   S_IDLE | normal arbitration, p0 first unless p1 has waited MAX_WAIT cycles
//   S_LOCK | loader owns memory; p0 held off until the burst ends or caps out
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int MAX_LOCK = DEF_MAX_LOCK
) (
    input logic                clk,
    input logic                rst_n,
    data_mem_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] LIM_WAIT = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] LIM_LOCK = CNT_W'(MAX_LOCK);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_p0_prio;
    logic              w_p0_prio_nxt;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_lock_inc;
    logic              w_lock_clr;
    logic              w_wait_inc;
    logic              w_wait_clr;
    logic [CNT_W-1:0]  w_wait_cnt;
    logic [CNT_W-1:0]  w_lock_cnt;
    rsel_t             r_rsel;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_mem_read;
    logic              w_mem_write;

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_wait_inc),
        .i_clr   (w_wait_clr),
        .i_limit (LIM_WAIT),
        .o_cnt   (w_wait_cnt)
    );

    sat_counter #(.W(CNT_W)) u_lock_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_lock_inc),
        .i_clr   (w_lock_clr),
        .i_limit (LIM_LOCK),
        .o_cnt   (w_lock_cnt)
    );

    // A refused loader request ages; a grant or a dropped request forgets it.
    assign w_wait_inc = bus.p1_req & ~w_gnt1;
    assign w_wait_clr = ~bus.p1_req | w_gnt1;

    // State and the one-shot "p0 goes next" flag after a capped burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_p0_prio <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_p0_prio <= w_p0_prio_nxt;
        end
    end

    // Grant selection, lock entry/exit and burst length bookkeeping.
    // Grants are held off while rst_n is low so every output reads zero in reset.
    always_comb begin
        w_state_nxt   = r_state;
        w_p0_prio_nxt = 1'b0;
        w_gnt0        = 1'b0;
        w_gnt1        = 1'b0;
        w_lock_inc    = 1'b0;
        w_lock_clr    = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_IDLE: begin
                    if (r_p0_prio && bus.p0_req) begin
                        w_gnt0 = 1'b1;
                    end else if (bus.p1_req && (!bus.p0_req || (w_wait_cnt == LIM_WAIT))) begin
                        w_gnt1 = 1'b1;
                    end else begin
                        w_gnt0 = bus.p0_req;
                    end
                    if (w_gnt1 && bus.p1_lock) begin
                        w_state_nxt = S_LOCK;
                        w_lock_inc  = 1'b1;
                    end
                end
                S_LOCK: begin
                    w_gnt1 = bus.p1_req;
                    if (!bus.p1_req || !bus.p1_lock) begin
                        w_state_nxt = S_IDLE;
                        w_lock_clr  = 1'b1;
                    end else if (w_lock_cnt == (LIM_LOCK - 1'b1)) begin
                        // This grant is the MAX_LOCK-th of the burst.
                        w_state_nxt   = S_IDLE;
                        w_lock_clr    = 1'b1;
                        w_p0_prio_nxt = 1'b1;
                    end else begin
                        w_lock_inc = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_lock_clr  = 1'b1;
                end
            endcase
        end
    end

    // Forward the winning port to data_mem; idle bus is driven to zero.
    always_comb begin
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        if (w_gnt1) begin
            w_mem_addr  = bus.p1_addr;
            w_mem_wdata = bus.p1_wdata;
            w_mem_read  = ~bus.p1_we;
            w_mem_write = bus.p1_we;
        end else if (w_gnt0) begin
            w_mem_addr  = bus.p0_addr;
            w_mem_wdata = bus.p0_wdata;
            w_mem_read  = ~bus.p0_we;
            w_mem_write = bus.p0_we;
        end
    end

    // Remember who issued this cycle's read so the data comes back to them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsel <= '{valid: 1'b0, port: PORT0};
        end else begin
            r_rsel.valid <= w_mem_read;
            r_rsel.port  <= w_gnt1 ? PORT1 : PORT0;
        end
    end

    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.mem_read  = w_mem_read;
    assign bus.mem_write = w_mem_write;

    assign bus.p0_gnt    = w_gnt0;
    assign bus.p1_gnt    = w_gnt1;
    assign bus.p0_stall  = rst_n & bus.p0_req & ~w_gnt0;

    assign bus.p0_rvalid = r_rsel.valid & (r_rsel.port == PORT0);
    assign bus.p1_rvalid = r_rsel.valid & (r_rsel.port == PORT1);
    assign bus.p0_rdata  = bus.mem_rdata;
    assign bus.p1_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a cycle model of the arbitration
// rules and a read-return scoreboard backed by a shadow of memory contents.
module tb_data_mem_arbiter;
    import data_mem_arbiter_pkg::*;

    localparam int MW = 4;
    localparam int ML = 8;

    logic clk;
    logic rst_n;

    data_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    data_mem_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (MW),
        .MAX_LOCK (ML)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_init(input int i);
        return 32'hC0DE_0000 ^ (i * 32'h0001_0101);
    endfunction

    // data_mem stand-in: synchronous write, registered read.
    logic [31:0] tbmem [0:1023];
    bit          tbval [0:1023];
    always @(posedge clk) begin
        if (bus.mem_write) begin
            tbmem[bus.mem_addr[11:2]] <= bus.mem_wdata;
            tbval[bus.mem_addr[11:2]] <= 1'b1;
        end
        if (bus.mem_read) begin
            bus.mem_rdata <= tbval[bus.mem_addr[11:2]] ? tbmem[bus.mem_addr[11:2]]
                                                       : mem_init(int'(bus.mem_addr[11:2]));
        end
    end

    typedef struct {
        bit          port;
        logic [31:0] data;
        int          cyc;
    } sb_t;

    sb_t         q[$];
    logic [31:0] exp_mem [int];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    bit m_lock, m_prio;
    int m_wait, m_lcnt;
    bit e_g0, e_g1;
    bit last_g0, last_g1, last_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        int i;
        i = int'(a[11:2]);
        return exp_mem.exists(i) ? exp_mem[i] : mem_init(i);
    endfunction

    task automatic set_in(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                          input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                          input bit l1);
        bus.p0_req = r0; bus.p0_we = w0; bus.p0_addr = a0; bus.p0_wdata = d0;
        bus.p1_req = r1; bus.p1_we = w1; bus.p1_addr = a1; bus.p1_wdata = d1;
        bus.p1_lock = l1;
    endtask

    task automatic model_eval();
        e_g0 = 1'b0;
        e_g1 = 1'b0;
        if (rst_n) begin
            if (m_lock) begin
                e_g1 = bus.p1_req;
            end else if (m_prio && bus.p0_req) begin
                e_g0 = 1'b1;
            end else begin
                e_g1 = bus.p1_req && (!bus.p0_req || m_wait == MW);
                e_g0 = bus.p0_req && !e_g1;
            end
        end
    endtask

    task automatic model_reset();
        m_lock = 0; m_prio = 0; m_wait = 0; m_lcnt = 0;
        q.delete();
    endtask

    task automatic check_cycle();
        logic [31:0] ea, ed, erd;
        bit er, ew, ev0, ev1;
        model_eval();
        ea  = e_g1 ? bus.p1_addr  : (e_g0 ? bus.p0_addr  : 32'h0);
        ed  = e_g1 ? bus.p1_wdata : (e_g0 ? bus.p0_wdata : 32'h0);
        er  = (e_g1 && !bus.p1_we) || (e_g0 && !bus.p0_we);
        ew  = (e_g1 &&  bus.p1_we) || (e_g0 &&  bus.p0_we);
        chk("p0_gnt",    32'(bus.p0_gnt),    32'(e_g0));
        chk("p1_gnt",    32'(bus.p1_gnt),    32'(e_g1));
        chk("p0_stall",  32'(bus.p0_stall),  32'(rst_n && bus.p0_req && !e_g0));
        chk("mem_read",  32'(bus.mem_read),  32'(er));
        chk("mem_write", 32'(bus.mem_write), 32'(ew));
        chk("mem_addr",  bus.mem_addr,  ea);
        chk("mem_wdata", bus.mem_wdata, ed);
        ev0 = 0; ev1 = 0; erd = 32'h0;
        while (q.size() > 0 && q[0].cyc < cyc) void'(q.pop_front());
        if (q.size() > 0 && q[0].cyc == cyc) begin
            if (q[0].port) ev1 = 1; else ev0 = 1;
            erd = q[0].data;
            void'(q.pop_front());
        end
        chk("p0_rvalid", 32'(bus.p0_rvalid), 32'(ev0));
        chk("p1_rvalid", 32'(bus.p1_rvalid), 32'(ev1));
        if (ev0) chk("p0_rdata", bus.p0_rdata, erd);
        if (ev1) chk("p1_rdata", bus.p1_rdata, erd);
        last_g0    = bus.p0_gnt;
        last_g1    = bus.p1_gnt;
        last_stall = bus.p0_stall;
    endtask

    task automatic model_update();
        sb_t e;
        model_eval();
        if (rst_n) begin
            if (e_g0) begin
                if (bus.p0_we) exp_mem[int'(bus.p0_addr[11:2])] = bus.p0_wdata;
                else begin e.port = 0; e.data = exp_rd(bus.p0_addr); e.cyc = cyc + 1; q.push_back(e); end
            end
            if (e_g1) begin
                if (bus.p1_we) exp_mem[int'(bus.p1_addr[11:2])] = bus.p1_wdata;
                else begin e.port = 1; e.data = exp_rd(bus.p1_addr); e.cyc = cyc + 1; q.push_back(e); end
            end
            m_prio = 0;
            if (!m_lock) begin
                if (e_g1 && bus.p1_lock) begin m_lock = 1; m_lcnt = 1; end
            end else if (!bus.p1_req || !bus.p1_lock) begin
                m_lock = 0; m_lcnt = 0;
            end else begin
                m_lcnt++;
                if (m_lcnt == ML) begin m_lock = 0; m_lcnt = 0; m_prio = 1; end
            end
            if (!bus.p1_req || e_g1) m_wait = 0;
            else if (m_wait < MW) m_wait++;
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt0"},  32'(bus.p0_gnt),    32'h0);
        chk({tag, "_gnt1"},  32'(bus.p1_gnt),    32'h0);
        chk({tag, "_stall"}, 32'(bus.p0_stall),  32'h0);
        chk({tag, "_rv0"},   32'(bus.p0_rvalid), 32'h0);
        chk({tag, "_rv1"},   32'(bus.p1_rvalid), 32'h0);
        chk({tag, "_rd"},    32'(bus.mem_read),  32'h0);
        chk({tag, "_wr"},    32'(bus.mem_write), 32'h0);
        chk({tag, "_addr"},  bus.mem_addr,       32'h0);
        chk({tag, "_wdata"}, bus.mem_wdata,      32'h0);
        chk({tag, "_state"}, 32'(dut.r_state),   32'(S_IDLE));
        chk({tag, "_wait"},  32'(dut.w_wait_cnt), 32'h0);
        chk({tag, "_lock"},  32'(dut.w_lock_cnt), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit g0h [20];
        bit g1h [20];
        int first, s, run;

        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        check_all_zero("reset0");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // idle bus
        step();
        step();

        // p0 read of 0x10, then write/read-back, then p1 read of the same word
        set_in(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
        step();
        chk("t1_p0_gnt", 32'(last_g0), 32'h1);
        set_in(1, 1, 32'h20, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        step();
        set_in(1, 0, 32'h20, 0, 0, 0, 0, 0, 0);
        step();
        set_in(0, 0, 0, 0, 1, 0, 32'h20, 0, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // contention: p1 wins on cycle MAX_WAIT+1
        set_in(1, 0, 32'h40, 0, 1, 0, 32'h44, 0, 0);
        first = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (last_g1 && first == 0) begin
                first = i;
                chk("t2_stall_at_p1", 32'(last_stall), 32'h1);
                chk("t2_wait_clr", 32'(dut.w_wait_cnt), 32'h0);
                bus.p1_req = 1'b0;
            end
        end
        chk("t2_first_p1", first, 32'(MW + 1));
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // locked loader writes vs continuous p0 reads
        for (int i = 0; i < 20; i++) begin
            set_in(1, 0, 32'h50, 0, 1, 1, 32'h60 + 32'(4 * (i % 4)), 32'h1000 + 32'(i), 1);
            step();
            g0h[i] = last_g0;
            g1h[i] = last_g1;
        end
        s = 19;
        for (int i = 19; i >= 0; i--) if (g1h[i]) s = i;
        chk("t3_first_p1", s, 32'(MW));
        if (s > 7) s = 7;
        run = 0;
        for (int j = s; j < 20 && g1h[j]; j++) run++;
        chk("t3_burst_len", run, 32'(ML));
        for (int j = s + ML; j < s + ML + MW; j++) chk("t3_p0_after", 32'(g0h[j]), 32'h1);
        chk("t3_p1_resume", 32'(g1h[s + ML + MW]), 32'h1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // loader lock released on its 3rd grant
        set_in(0, 0, 0, 0, 1, 0, 32'h60, 0, 1);
        step();
        chk("t4_g1_c1", 32'(last_g1), 32'h1);
        set_in(1, 0, 32'h50, 0, 1, 0, 32'h64, 0, 1);
        step();
        chk("t4_g1_c2", 32'(last_g1), 32'h1);
        chk("t4_lock_c2", 32'(dut.r_state), 32'(S_LOCK));
        set_in(1, 0, 32'h50, 0, 1, 0, 32'h68, 0, 0);
        step();
        chk("t4_g1_c3", 32'(last_g1), 32'h1);
        chk("t4_idle_c3", 32'(dut.r_state), 32'(S_IDLE));
        set_in(1, 0, 32'h54, 0, 1, 0, 32'h6C, 0, 0);
        step();
        chk("t4_g0_c4", 32'(last_g0), 32'h1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // reset the cycle after a granted (locking) p1 read
        set_in(0, 0, 0, 0, 1, 0, 32'h64, 0, 1);
        step();
        chk("t5_g1", 32'(last_g1), 32'h1);
        rst_n = 1'b0;
        set_in(1, 0, 32'h10, 0, 1, 0, 32'h64, 0, 1);
        @(negedge clk);
        check_all_zero("t5_rst");
        model_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        model_update();
        #1;

        // back to normal after reset
        set_in(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
